// File: rtl/mips_mem_pkg.sv
// Shared definitions for the CPU-side memory bus master.
//   mem_size_e  : access size encoding carried on cpu_size
//   bus_state_e : state encoding of the bus master FSM
package mips_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } bus_state_e;

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational lane logic for a CPU access.
// Ports:
//   size       in  2   access size (byte/half/word, 3 illegal)
//   addr_lo    in  2   low byte-address bits
//   wdata      in  32  right-justified store data
//   byteenable out 4   active byte lanes
//   writedata  out 32  store data replicated across the active lanes
//   err        out 1   illegal size or misaligned address
import mips_mem_pkg::*;

module mem_lane_gen (
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic        err
);

   always_comb begin
      byteenable = 4'b0000;
      writedata  = wdata;
      err        = 1'b0;
      case (size)
         SZ_BYTE: begin
            byteenable = 4'b0001 << addr_lo;
            writedata  = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
            writedata  = {2{wdata[15:0]}};
            err        = addr_lo[0];
         end
         SZ_WORD: begin
            byteenable = 4'b1111;
            err        = |addr_lo;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_bus_master.sv
// CPU-to-memory bus master: turns a single CPU request into one
// read/write bus transaction with waitrequest stalls and a stall timeout.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cpu_req/we/addr/size/wdata   in    CPU request (sampled in IDLE only)
//   cpu_busy/done/err/rdata      out   CPU status and read data
//   address/read/write/byteenable/writedata  out  bus command
//   waitrequest/readdata         in    bus slave response
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | waiting for cpu_req
// ST_BUS  | strobe asserted, waiting for waitrequest low or timeout
// ST_DONE | one-cycle cpu_done pulse (cpu_err set on error/timeout)
import mips_mem_pkg::*;

module mem_bus_master #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [1:0]  cpu_size,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   // Abort fires on the stall cycle that brings the count up to WAIT_LIMIT.
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

   bus_state_e  state;
   logic [7:0]  wait_cnt;
   logic [3:0]  lg_be;
   logic [31:0] lg_wd;
   logic        lg_err;

   mem_lane_gen u_lane (
      .size       (cpu_size),
      .addr_lo    (cpu_addr[1:0]),
      .wdata      (cpu_wdata),
      .byteenable (lg_be),
      .writedata  (lg_wd),
      .err        (lg_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         wait_cnt   <= 8'd0;
         cpu_busy   <= 1'b0;
         cpu_done   <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_rdata  <= 32'd0;
         address    <= 32'd0;
         read       <= 1'b0;
         write      <= 1'b0;
         byteenable <= 4'd0;
         writedata  <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               cpu_done <= 1'b0;
               cpu_err  <= 1'b0;
               if (cpu_req) begin
                  cpu_busy <= 1'b1;
                  if (lg_err) begin
                     // Bad accesses never reach the bus.
                     state    <= ST_DONE;
                     cpu_done <= 1'b1;
                     cpu_err  <= 1'b1;
                  end else begin
                     state      <= ST_BUS;
                     read       <= ~cpu_we;
                     write      <= cpu_we;
                     address    <= {cpu_addr[31:2], 2'b00};
                     byteenable <= lg_be;
                     writedata  <= lg_wd;
                     wait_cnt   <= 8'd0;
                  end
               end
            end
            ST_BUS: begin
               if (!waitrequest) begin
                  read     <= 1'b0;
                  write    <= 1'b0;
                  if (read) cpu_rdata <= readdata;
                  state    <= ST_DONE;
                  cpu_done <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt == WAIT_LAST) begin
                     read     <= 1'b0;
                     write    <= 1'b0;
                     state    <= ST_DONE;
                     cpu_done <= 1'b1;
                     cpu_err  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               cpu_done <= 1'b0;
               cpu_err  <= 1'b0;
               cpu_busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               state    <= ST_IDLE;
               cpu_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
